// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte transmitter between NUM_REQ producers.
// Captures the winning byte, pulses tx_start and paces a full frame with its own baud tick.
//
// state | meaning
// IDLE  | waiting for any req_valid; baud counter held at 0
// START | one-cycle handshake: tx_start and req_ready[grant_id] high
// SEND  | baud counter running; FRAME_BITS baud ticks until the frame ends
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_BITS   = 10,
  parameter int ID_W         = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_byte,
  output logic                   tx_start,
  output logic                   baud_tick,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int TICK_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, START, SEND} state_t;

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     sel_idx;
  logic                sel_found;
  logic [NUM_REQ-1:0]  valid_sh;
  logic [8*NUM_REQ-1:0] data_sh;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BAUD_W-1:0]   baud_nxt;
  logic [TICK_W-1:0]   tick_cnt;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    valid_sh  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      valid_sh = req_valid >> ((int'(ptr) + k) % NUM_REQ);
      if (!sel_found && valid_sh[0]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign data_sh  = req_data >> (8 * sel_idx);
  assign baud_nxt = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1)) ? '0 : baud_cnt + BAUD_W'(1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= ID_W'(NUM_REQ - 1);
      tx_byte   <= '0;
      grant_id  <= '0;
      tx_start  <= 1'b0;
      req_ready <= '0;
      baud_tick <= 1'b0;
      baud_cnt  <= '0;
      tick_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt  <= '0;
          baud_tick <= 1'b0;
          tx_start  <= 1'b0;
          req_ready <= '0;
          if (sel_found) begin
            state     <= START;
            tx_byte   <= data_sh[7:0];
            grant_id  <= sel_idx;
            ptr       <= sel_idx;
            tx_start  <= 1'b1;
            req_ready <= NUM_REQ'(1) << sel_idx;
          end
        end
        START: begin
          tx_start  <= 1'b0;
          req_ready <= '0;
          baud_cnt  <= '0;
          tick_cnt  <= '0;
          baud_tick <= 1'b0;
          state     <= SEND;
        end
        SEND: begin
          baud_cnt  <= baud_nxt;
          baud_tick <= (baud_nxt == BAUD_W'(CLKS_PER_BIT - 1));
          if (baud_tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            if (tick_cnt == TICK_W'(FRAME_BITS - 1)) begin
              state     <= IDLE;
              baud_cnt  <= '0;
              baud_tick <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          tx_start  <= 1'b0;
          req_ready <= '0;
          baud_tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized
// request traffic compared against a round-robin model.
module tb_uart_tx_scheduler;

  localparam int N      = 4;
  localparam int CPB    = 16;
  localparam int FB     = 10;
  localparam int FRAME  = 1 + FB * CPB;
  localparam int PERIOD = FRAME + 1;
  localparam int PERIOD1 = 2 + FB * 2;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_byte;
  logic           tx_start;
  logic           baud_tick;
  logic [1:0]     grant_id;
  logic           busy;

  logic [0:0]     v1 = '0;
  logic [7:0]     d1 = '0;
  logic [0:0]     ready1;
  logic [7:0]     tx_byte1;
  logic           tx_start1;
  logic           tick1;
  logic [0:0]     gid1;
  logic           busy1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_cnt [N];
  int model_ptr = N - 1;

  uart_tx_scheduler #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .ID_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_byte(tx_byte), .tx_start(tx_start), .baud_tick(baud_tick),
    .grant_id(grant_id), .busy(busy));

  uart_tx_scheduler #(.NUM_REQ(1), .CLKS_PER_BIT(2), .FRAME_BITS(10), .ID_W(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(v1), .req_data(d1),
    .req_ready(ready1), .tx_byte(tx_byte1), .tx_start(tx_start1), .baud_tick(tick1),
    .grant_id(gid1), .busy(busy1));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required to finish");
    $fatal(1);
  end

  // req_ready must be one-hot and only alongside tx_start
  always @(negedge clock) begin
    if (reset_n) begin
      checks++;
      if ((tx_start !== (req_ready != '0)) || ($countones(req_ready) > 1)) begin
        errors++;
        $display("FAIL ready_align: req_ready=%b tx_start=%b, required one-hot with tx_start", req_ready, tx_start);
      end
      for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) ready_cnt[i]++;
    end
  end

  // Round-robin rule: first requester after the last winner, wrapping around.
  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    int order [$];
    for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0;
    req_valid = '0;
    v1 = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_ptr = N - 1;
  endtask

  task automatic wait_start(input int limit, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (tx_start === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge clock);
      if (busy === 1'b0) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: busy=%b, required 0 within frame", busy);
  endtask

  task automatic measure_frame(output int busy_cnt, output int nticks, output int bad_space);
    int off;
    off = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    nticks = 0;
    bad_space = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      @(negedge clock);
      off++;
      if (busy !== 1'b1) break;
      busy_cnt++;
      if (baud_tick === 1'b1) begin
        nticks++;
        if (off != CPB * nticks) bad_space++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({tx_start, baud_tick, busy, req_ready, tx_byte, grant_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b tick=%b busy=%b ready=%b byte=%h gid=%0d, required all 0",
               tx_start, baud_tick, busy, req_ready, tx_byte, grant_id);
    end
    checks++;
    if ({tx_start1, tick1, busy1, ready1, tx_byte1, gid1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_n1: start=%b tick=%b busy=%b, required all 0", tx_start1, tick1, busy1);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int bc, nt, bs;
    req_data = {$urandom, 8'hA5} >> 8;
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    @(negedge clock);
    checks++;
    if (tx_start !== 1'b1 || req_ready !== 4'b0001 || tx_byte !== 8'hA5 || grant_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_start: start=%b ready=%b byte=%h gid=%0d busy=%b, required 1 0001 a5 0 1",
               tx_start, req_ready, tx_byte, grant_id, busy);
    end
    req_valid = '0;
    model_ptr = 0;
    measure_frame(bc, nt, bs);
    checks++;
    if (bc != FRAME) begin
      errors++;
      $display("FAIL single_busy_len: got %0d, required %0d", bc, FRAME);
    end
    checks++;
    if (nt != FB || bs != 0) begin
      errors++;
      $display("FAIL single_ticks: got %0d ticks with %0d misplaced, required %0d ticks every %0d", nt, bs, FB, CPB);
    end
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    int exp_cnt [N];
    bit ok;
    int at, prev_at, exp;
    logic [7:0] exp_byte;
    apply_reset();
    for (int i = 0; i < N; i++) begin ready_cnt[i] = 0; exp_cnt[i] = 0; end
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = 4'b1111;
    prev_at = 0;
    for (int g = 0; g < 5; g++) begin
      wait_start(PERIOD + 5, ok, at);
      exp = rr_pick(model_ptr, req_valid);
      exp_byte = 8'h10 + 8'(8'h11 * exp);
      checks++;
      if (!ok || exp != seq[g] || grant_id !== 2'(exp) || tx_byte !== exp_byte || req_ready !== (4'b0001 << exp)) begin
        errors++;
        $display("FAIL rr_grant%0d: ok=%0d gid=%0d byte=%h ready=%b, required gid %0d byte %h", g, ok, grant_id, tx_byte, req_ready, seq[g], exp_byte);
      end
      if (g > 0) begin
        checks++;
        if (at - prev_at != PERIOD) begin
          errors++;
          $display("FAIL rr_period%0d: got %0d, required %0d", g, at - prev_at, PERIOD);
        end
      end
      prev_at = at;
      model_ptr = exp;
      if (exp >= 0) exp_cnt[exp]++;
      if (g == 4) req_valid = '0;
    end
    wait_idle();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ready_cnt[i] != exp_cnt[i]) begin
        errors++;
        $display("FAIL rr_ready_count%0d: got %0d, required %0d", i, ready_cnt[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int at, prev_at;
    int want [2] = '{0, 1};
    logic [N-1:0] dd;
    apply_reset();
    req_data = {$urandom};
    req_valid = 4'b0100;
    wait_start(5, ok, at);
    checks++;
    if (!ok || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL wrap_setup: ok=%0d gid=%0d, required 2", ok, grant_id);
    end
    model_ptr = 2;
    req_valid = 4'b0011;
    prev_at = at;
    for (int g = 0; g < 2; g++) begin
      wait_start(PERIOD + 5, ok, at);
      checks++;
      if (!ok || rr_pick(model_ptr, req_valid) != want[g] || grant_id !== 2'(want[g]) ||
          tx_byte !== req_data[8*want[g] +: 8] || at - prev_at != PERIOD) begin
        errors++;
        $display("FAIL wrap_grant%0d: ok=%0d gid=%0d byte=%h gap=%0d, required gid %0d gap %0d",
                 g, ok, grant_id, tx_byte, at - prev_at, want[g], PERIOD);
      end
      model_ptr = want[g];
      prev_at = at;
      dd = req_valid;
      dd[want[g]] = 1'b0;
      req_valid = dd;
    end
    wait_idle();
  endtask

  task automatic test_ignore();
    bit ok;
    int at, base3, extra;
    logic [7:0] b0;
    b0 = 8'($urandom_range(1, 255));
    req_data[7:0] = b0;
    req_valid = 4'b0001;
    wait_start(5, ok, at);
    req_valid = '0;
    model_ptr = 0;
    base3 = ready_cnt[3];
    repeat (30) @(negedge clock);
    req_valid = 4'b1000;
    repeat (5) @(negedge clock);
    req_valid = '0;
    extra = 0;
    for (int i = 0; i < PERIOD + 40; i++) begin
      @(negedge clock);
      if (tx_start === 1'b1) extra++;
    end
    checks++;
    if (!ok || extra != 0 || ready_cnt[3] != base3) begin
      errors++;
      $display("FAIL ignore_pulse: ok=%0d extra_starts=%0d ready3=%0d, required 1 0 %0d", ok, extra, ready_cnt[3], base3);
    end
    checks++;
    if (grant_id !== 2'd0 || tx_byte !== b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_frame: gid=%0d byte=%h busy=%b, required 0 %h 0", grant_id, tx_byte, busy, b0);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int at, bc, nt, bs, exp;
    req_data = {$urandom};
    req_data[7:0] = 8'h5A;
    req_valid = 4'b0001;
    wait_start(5, ok, at);
    req_valid = '0;
    repeat (50) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({tx_start, baud_tick, busy, req_ready, tx_byte, grant_id} !== '0) begin
      errors++;
      $display("FAIL async_reset: start=%b tick=%b busy=%b ready=%b byte=%h gid=%0d, required all 0",
               tx_start, baud_tick, busy, req_ready, tx_byte, grant_id);
    end
    @(negedge clock);
    req_valid = 4'b0010;
    @(negedge clock);
    reset_n = 1'b1;
    model_ptr = N - 1;
    exp = rr_pick(model_ptr, req_valid);
    wait_start(1, ok, at);
    checks++;
    if (!ok || exp != 1 || grant_id !== 2'd1 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL post_reset_grant: ok=%0d gid=%0d ready=%b, required 1 0010", ok, grant_id, req_ready);
    end
    req_valid = '0;
    model_ptr = 1;
    measure_frame(bc, nt, bs);
    checks++;
    if (bc != FRAME || nt != FB || bs != 0) begin
      errors++;
      $display("FAIL post_reset_frame: busy=%0d ticks=%0d misplaced=%0d, required %0d %0d 0", bc, nt, bs, FRAME, FB);
    end
  endtask

  task automatic test_random();
    bit pend [N];
    logic [7:0] pbyte [N];
    logic [N-1:0] drv;
    int grants, exp;
    grants = 0;
    drv = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pbyte[i] = '0; end
    for (int c = 0; c < 9000 && grants < 25; c++) begin
      @(negedge clock);
      if (tx_start === 1'b1) begin
        exp = rr_pick(model_ptr, drv);
        checks++;
        if (exp < 0 || grant_id !== 2'(exp) || tx_byte !== pbyte[exp] || req_ready !== (4'b0001 << exp)) begin
          errors++;
          $display("FAIL random_grant%0d: gid=%0d byte=%h ready=%b, required gid %0d byte %h",
                   grants, grant_id, tx_byte, req_ready, exp, (exp >= 0) ? pbyte[exp] : 8'h00);
        end
        if (exp >= 0) begin
          model_ptr = exp;
          pend[exp] = 1'b0;
        end
        grants++;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b1;
          pbyte[i] = 8'($urandom);
        end
      end
      for (int i = 0; i < N; i++) begin
        drv[i] = pend[i];
        req_data[8*i +: 8] = pbyte[i];
      end
      req_valid = drv;
    end
    checks++;
    if (grants < 25) begin
      errors++;
      $display("FAIL random_progress: got %0d grants, required 25", grants);
    end
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_single_req();
    int starts, last_start, last_tick, ticks_in_frame;
    logic [7:0] cur;
    starts = 0;
    last_start = 0;
    last_tick = 0;
    ticks_in_frame = 0;
    cur = 8'($urandom);
    d1 = cur;
    v1 = 1'b1;
    for (int c = 0; c < 200 && starts < 5; c++) begin
      @(negedge clock);
      if (tx_start1 === 1'b1) begin
        checks++;
        if (gid1 !== 1'b0 || tx_byte1 !== cur || ready1 !== 1'b1) begin
          errors++;
          $display("FAIL n1_grant%0d: gid=%0d byte=%h ready=%b, required 0 %h 1", starts, gid1, tx_byte1, ready1, cur);
        end
        if (starts > 0) begin
          checks++;
          if (cyc - last_start != PERIOD1 || ticks_in_frame != 10) begin
            errors++;
            $display("FAIL n1_period%0d: gap=%0d ticks=%0d, required %0d 10", starts, cyc - last_start, ticks_in_frame, PERIOD1);
          end
        end
        starts++;
        last_start = cyc;
        last_tick = cyc;
        ticks_in_frame = 0;
        cur = 8'($urandom);
        d1 = cur;
      end
      if (tick1 === 1'b1) begin
        checks++;
        if (cyc - last_tick != 2) begin
          errors++;
          $display("FAIL n1_tick_spacing: got %0d, required 2", cyc - last_tick);
        end
        last_tick = cyc;
        ticks_in_frame++;
      end
    end
    checks++;
    if (starts < 5) begin
      errors++;
      $display("FAIL n1_progress: got %0d starts, required 5", starts);
    end
    v1 = 1'b0;
    repeat (30) @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_ignore();
    test_reset_midframe();
    test_random();
    test_single_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
